// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: default format, divider FSM states,
// saturation constants and a magnitude helper.
package fixed_point_pkg;

  localparam int N_DEF = 16;
  localparam int Q_DEF = 8;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;

  localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] MAX_NEG = {1'b1, {(N_DEF-1){1'b0}}};

  // Operands are sign-extended to 32 bits first, so the most negative
  // N-bit value gets its true magnitude (e.g. 0x8000 -> 32768).
  function automatic logic [31:0] twos_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/fixed_point_divider_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_restoring_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W-1:0] sub;

  // A kept remainder is always below the divisor, so W bits suffice.
  assign qbit_o = (rem_i >= {1'b0, div_i});
  assign sub    = W'(rem_i - {1'b0, div_i});
  assign rem_o  = qbit_o ? sub : rem_i[W-1:0];

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider C = A / B, one quotient bit per clock,
// saturating. Define FIXED_POINT_DIVIDER_ROUND_EN for round-half-away-from-zero.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ready,
  output logic [N-1:0] C,
  output logic         valid,
  output logic         div_by_zero,
  output logic         overflow
);

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  localparam int ITER = N + Q + 1;
`else
  localparam int ITER = N + Q;
`endif
  localparam int MAG_W = ITER + 1;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [N-1:0]     SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     SAT_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [MAG_W-1:0] LIM_POS = MAG_W'(SAT_POS);
  localparam logic [MAG_W-1:0] LIM_NEG = MAG_W'(SAT_NEG);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             dz_q, dz_d;
  logic [N-1:0]     bmag_q, bmag_d;
  logic [ITER-1:0]  num_q, num_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [N-1:0]     c_q, c_d;
  logic             valid_q, valid_d;
  logic             dzf_q, dzf_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     a_abs, b_abs, rem_next, mag_n;
  logic             qbit;
  logic [MAG_W-1:0] mag, lim;

  div_restoring_step #(.W(N)) u_step (
    .rem_i  ({rem_q, num_q[ITER-1]}),
    .div_i  (bmag_q),
    .rem_o  (rem_next),
    .qbit_o (qbit)
  );

  assign a_abs = N'(twos_abs(32'(signed'(A))));
  assign b_abs = N'(twos_abs(32'(signed'(B))));

  // Truncated quotient magnitude, or with the extra half-LSB bit folded in.
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  assign mag = MAG_W'(quo_q[ITER-1:1]) + MAG_W'(quo_q[0]);
`else
  assign mag = MAG_W'(quo_q);
`endif
  assign lim   = sign_q ? LIM_NEG : LIM_POS;
  assign mag_n = (mag > lim) ? N'(lim) : N'(mag);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    bmag_d  = bmag_q;
    num_d   = num_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    c_d     = c_q;
    valid_d = 1'b0;
    dzf_d   = dzf_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = A[N-1] ^ B[N-1];
          dz_d    = (B == '0);
          bmag_d  = b_abs;
          num_d   = {a_abs, {(ITER-N){1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = (B == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = {quo_q[ITER-2:0], qbit};
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER-1)) state_d = FIX;
      end
      FIX: begin
        valid_d = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          c_d   = sign_q ? SAT_NEG : SAT_POS;
          dzf_d = 1'b1;
          ovf_d = 1'b0;
        end else begin
          c_d   = sign_q ? (~mag_n + 1'b1) : mag_n;
          dzf_d = 1'b0;
          ovf_d = (mag > lim);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      bmag_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      dzf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      bmag_q  <= bmag_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      dzf_q   <= dzf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign C           = c_q;
  assign valid       = valid_q;
  assign div_by_zero = dzf_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Bench for fixed_point_divider (Q8.8): directed vector table, control
// corner cases, and random operands against an arithmetic reference model.
module tb_fixed_point_divider;
  import fixed_point_pkg::*;

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  localparam int LAT = 27;
  localparam logic [15:0] RND_EXP = 16'h00AB;
`else
  localparam int LAT = 26;
  localparam logic [15:0] RND_EXP = 16'h00AA;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        ready, valid, div_by_zero, overflow;
  logic [15:0] C;

  int n_checks = 0;
  int n_fail   = 0;

  fixed_point_divider #(.N(16), .Q(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .C(C), .valid(valid),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, c;
    logic        dz, ov;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient of the magnitudes scaled by 2^Q, then
  // rounding, clamping to the signed range and reapplying the sign.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] c, output logic dz, output logic ov);
    longint sa, sb, ma, mb, q, lim, r;
    bit neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    if (b == 16'h0) begin
      c = a[15] ? MAX_NEG : MAX_POS;
      dz = 1'b1;
      ov = 1'b0;
    end else begin
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
      q = ((ma * 512) / mb + 1) / 2;
`else
      q = (ma * 256) / mb;
`endif
      lim = neg ? 32768 : 32767;
      ov  = q > lim;
      if (q > lim) q = lim;
      r = neg ? -q : q;
      c = r[15:0];
      dz = 1'b0;
    end
  endtask

  // Start is already driven; it is accepted at the next edge. Latency counts
  // the start cycle as cycle 1. pulse_at injects a junk start while busy.
  task automatic wait_result(input int pulse_at, output logic [15:0] c,
                             output logic dz, output logic ov,
                             output int lat, output logic rdy5);
    int n;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    lat = -1;
    rdy5 = 1'b1;
    c = 'x; dz = 1'bx; ov = 1'bx;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 5) rdy5 = ready;
      if (valid) begin
        lat = n + 1;
        c = C; dz = div_by_zero; ov = overflow;
        break;
      end
      if (n == pulse_at) begin
        A = 16'h1234; B = 16'h0000; start = 1'b1;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no valid within 100 cycles");
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                       output logic [15:0] c, output logic dz, output logic ov,
                       output int lat, output logic rdy5);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    wait_result(pulse_at, c, dz, ov, lat, rdy5);
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
  endtask

  vec_t        tbl[10];
  logic [15:0] c, ec;
  logic        dz, ov, edz, eov, rdy5;
  int          lat, nv;

  initial begin
    tbl[0] = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    tbl[1] = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    tbl[2] = '{16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0500, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h4000, 16'h0080, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'hC000, 16'h0080, 16'h8000, 1'b0, 1'b0};
    tbl[6] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0};
    tbl[7] = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b0};
    tbl[8] = '{16'h0002, 16'h0003, RND_EXP,  1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_valid", valid, 0);
    check("reset_C", C, 0);
    check("reset_dz", div_by_zero, 0);
    check("reset_ovf", overflow, 0);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, -1, c, dz, ov, lat, rdy5);
      check($sformatf("vec%0d_C", i), c, tbl[i].c);
      check($sformatf("vec%0d_dz", i), dz, tbl[i].dz);
      check($sformatf("vec%0d_ovf", i), ov, tbl[i].ov);
      check($sformatf("vec%0d_lat", i), lat, (tbl[i].b == 16'h0) ? 2 : LAT);
      if (i == 0) check("calc_ready_low", rdy5, 0);
      if (i == 0) check("valid_cycle_ready", ready, 1);
    end

    // Start pulsed while busy must be ignored entirely.
    do_op(16'h0300, 16'h0200, 5, c, dz, ov, lat, rdy5);
    check("busy_C", c, 16'h0180);
    check("busy_lat", lat, LAT);
    count_valids(40, nv);
    check("busy_no_extra_valid", nv, 0);

    // Start in the valid cycle is taken back-to-back.
    do_op(16'h0500, 16'h0200, -1, c, dz, ov, lat, rdy5);
    check("b2b_first_C", c, 16'h0280);
    A = 16'hFD00; B = 16'h0200; start = 1'b1;
    wait_result(-1, c, dz, ov, lat, rdy5);
    check("b2b_second_C", c, 16'hFE80);
    check("b2b_second_lat", lat, LAT);

    // Reset during CALC aborts: no valid, outputs cleared.
    @(negedge clk);
    A = 16'h0300; B = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("abort_ready_in_reset", ready, 1);
    check("abort_C_in_reset", C, 0);
    @(negedge clk) rst = 1'b1;
    count_valids(40, nv);
    check("abort_no_valid", nv, 0);
    check("abort_C", C, 0);
    check("abort_ready", ready, 1);

    // Random operands against the model; some zero and tiny divisors.
    for (int k = 0; k < 200; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 16'h0000;
        1, 2:    rb = 16'($urandom_range(1, 255)) ^ ($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
        3:       rb = 16'h8000;
        default: rb = 16'($urandom);
      endcase
      if (k == 0) ra = 16'h8000;
      model(ra, rb, ec, edz, eov);
      do_op(ra, rb, -1, c, dz, ov, lat, rdy5);
      check($sformatf("rnd%0d_C(%h/%h)", k, ra, rb), c, ec);
      check($sformatf("rnd%0d_dz", k), dz, edz);
      check($sformatf("rnd%0d_ovf", k), ov, eov);
      check($sformatf("rnd%0d_lat", k), lat, (rb == 16'h0) ? 2 : LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
